// File: rtl/ifu_fetch.sv
// ifu_fetch: fetch stage between the PC register and decode.
// Issues one instruction-bus request at a time and waits for its response.
// The fetched word and its PC reach decode through a valid/ready register.
// Drives the PC hold flag and squashes in-flight work on a jump.
// Ports:
//   clk, rst (sync, active-low)
//   pc_in, jump_flag_in, pc_hold_out              : PC register side
//   ibus_req_valid_out/addr_out, ibus_req_ready_in : request channel
//   ibus_rsp_valid_in/data_in/err_in               : response channel
//   id_valid_out, id_ready_in                      : decode handshake
//   id_inst_out, id_pc_out, id_exc_out             : decode payload
//   id_exc_out codes: 0 none, 1 misaligned, 2 bus error, 3 timeout
module ifu_fetch #(
  parameter logic [31:0] NOP_INST     = 32'h0000_0013,
  parameter int unsigned RESP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        jump_flag_in,
  output logic        pc_hold_out,
  output logic        ibus_req_valid_out,
  output logic [31:0] ibus_req_addr_out,
  input  logic        ibus_req_ready_in,
  input  logic        ibus_rsp_valid_in,
  input  logic [31:0] ibus_rsp_data_in,
  input  logic        ibus_rsp_err_in,
  output logic        id_valid_out,
  input  logic        id_ready_in,
  output logic [31:0] id_inst_out,
  output logic [31:0] id_pc_out,
  output logic [1:0]  id_exc_out
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } state_e;

  localparam int unsigned CW =
    (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(RESP_TIMEOUT - 1);
  localparam logic TMO_EN = (RESP_TIMEOUT != 0);

  state_e        state_q, state_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [31:0]   pc_q, pc_d;
  logic          id_valid_q, id_valid_d;
  logic [31:0]   id_inst_q, id_inst_d;
  logic [31:0]   id_pc_q, id_pc_d;
  logic [1:0]    id_exc_q, id_exc_d;

  logic aligned;
  logic req_valid;
  logic hs;
  logic squash;
  logic tmo_hit;

  assign aligned   = (pc_in[1:0] == 2'b00);
  // rst gates the request so reset holds the bus idle from the first cycle
  assign req_valid = rst & (state_q == S_REQ)
                   & ~jump_flag_in & aligned;
  assign hs        = req_valid & ibus_req_ready_in;
  // a jump in the response cycle makes that response wrong-path too
  assign squash    = drop_q | jump_flag_in;
  assign tmo_hit   = TMO_EN & (tmo_q == TMO_LAST);

  assign ibus_req_valid_out = req_valid;
  assign ibus_req_addr_out  = pc_in;
  assign pc_hold_out        = ~hs;
  assign id_valid_out       = id_valid_q;
  assign id_inst_out        = id_inst_q;
  assign id_pc_out          = id_pc_q;
  assign id_exc_out         = id_exc_q;

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    tmo_d      = '0;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_exc_d   = id_exc_q;
    unique case (state_q)
      S_REQ: begin
        // late response of a timed-out request
        if (ibus_rsp_valid_in) drop_d = 1'b0;
        if (!jump_flag_in) begin
          if (!aligned) begin
            state_d    = S_OUT;
            id_valid_d = 1'b1;
            id_inst_d  = NOP_INST;
            id_pc_d    = pc_in;
            id_exc_d   = 2'd1;
          end else if (hs) begin
            state_d = S_WAIT;
            pc_d    = pc_in;
          end
        end
      end
      S_WAIT: begin
        if (ibus_rsp_valid_in) begin
          if (squash) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            state_d    = S_OUT;
            id_valid_d = 1'b1;
            id_inst_d  = ibus_rsp_data_in;
            id_pc_d    = pc_q;
            id_exc_d   = ibus_rsp_err_in ? 2'd2 : 2'd0;
          end
        end else if (tmo_hit) begin
          // response may still come; it must be ignored
          drop_d = 1'b1;
          if (squash) begin
            state_d = S_REQ;
          end else begin
            state_d    = S_OUT;
            id_valid_d = 1'b1;
            id_inst_d  = NOP_INST;
            id_pc_d    = pc_q;
            id_exc_d   = 2'd3;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (jump_flag_in) drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (ibus_rsp_valid_in) drop_d = 1'b0;
        if (id_ready_in || jump_flag_in) begin
          state_d    = S_REQ;
          id_valid_d = 1'b0;
          id_inst_d  = NOP_INST;
          id_exc_d   = 2'd0;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_REQ;
      drop_q     <= 1'b0;
      tmo_q      <= '0;
      pc_q       <= '0;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= '0;
      id_exc_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      tmo_q      <= tmo_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_exc_q   <= id_exc_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch.
// A transaction-level model is checked every cycle plus literal expectations.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        jump;
  logic        hold;
  logic        req_v;
  logic [31:0] req_a;
  logic        req_rdy;
  logic        rsp_v;
  logic [31:0] rsp_d;
  logic        rsp_err;
  logic        id_v;
  logic        id_rdy;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [1:0]  id_exc;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  ifu_fetch #(
    .NOP_INST     (NOP),
    .RESP_TIMEOUT (TMO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pc_in              (pc_in),
    .jump_flag_in       (jump),
    .pc_hold_out        (hold),
    .ibus_req_valid_out (req_v),
    .ibus_req_addr_out  (req_a),
    .ibus_req_ready_in  (req_rdy),
    .ibus_rsp_valid_in  (rsp_v),
    .ibus_rsp_data_in   (rsp_d),
    .ibus_rsp_err_in    (rsp_err),
    .id_valid_out       (id_v),
    .id_ready_in        (id_rdy),
    .id_inst_out        (id_inst),
    .id_pc_out          (id_pc),
    .id_exc_out         (id_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Transaction-level view: a presented instruction, an outstanding
  // request with its wait time, and whether the next response is junk.
  typedef struct packed {
    logic        out_v;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  exc;
    logic        busy;
    logic [31:0] wpc;
    logic [31:0] waited;
    logic        ignore;
  } m_t;

  m_t m;

  function automatic m_t nxt();
    m_t n;
    n = m;
    if (!rst) begin
      n      = '0;
      n.inst = NOP;
      return n;
    end
    if (m.out_v) begin
      if (rsp_v) n.ignore = 1'b0;
      if (id_rdy || jump) begin
        n.out_v = 1'b0;
        n.inst  = NOP;
      end
    end else if (m.busy) begin
      if (rsp_v) begin
        n.busy = 1'b0;
        if (m.ignore || jump) begin
          n.ignore = 1'b0;
        end else begin
          n.out_v = 1'b1;
          n.inst  = rsp_d;
          n.pc    = m.wpc;
          n.exc   = rsp_err ? 2'd2 : 2'd0;
        end
      end else begin
        n.waited = m.waited + 1;
        if (jump) n.ignore = 1'b1;
        if (TMO > 0 && n.waited == TMO) begin
          n.busy   = 1'b0;
          n.ignore = 1'b1;
          if (!(m.ignore || jump)) begin
            n.out_v = 1'b1;
            n.inst  = NOP;
            n.pc    = m.wpc;
            n.exc   = 2'd3;
          end
        end
      end
    end else begin
      if (rsp_v) n.ignore = 1'b0;
      if (!jump) begin
        if (pc_in[1:0] != 2'b00) begin
          n.out_v = 1'b1;
          n.inst  = NOP;
          n.pc    = pc_in;
          n.exc   = 2'd1;
        end else if (req_rdy) begin
          n.busy   = 1'b1;
          n.wpc    = pc_in;
          n.waited = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= nxt();

  always @(negedge clk) begin
    if (chk_en) begin
      automatic logic erv;
      erv = rst && !m.busy && !m.out_v && !jump
          && (pc_in[1:0] == 2'b00);
      chk("m_req_valid", req_v, erv);
      if (erv) chk("m_req_addr", req_a, pc_in);
      chk("m_pc_hold", hold, !(erv && req_rdy));
      chk("m_id_valid", id_v, m.out_v);
      chk("m_id_inst", id_inst, m.inst);
      if (m.out_v) begin
        chk("m_id_pc", id_pc, m.pc);
        chk("m_id_exc", id_exc, m.exc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, id_v, 1'b0);
    chk({tag, "_inst"}, id_inst, NOP);
    chk({tag, "_pc"}, id_pc, 32'h0);
    chk({tag, "_exc"}, id_exc, 2'd0);
    chk({tag, "_reqv"}, req_v, 1'b0);
    chk({tag, "_hold"}, hold, 1'b1);
  endtask

  initial begin
    rst = 1'b0; pc_in = '0; jump = 1'b0;
    req_rdy = 1'b0; rsp_v = 1'b0; rsp_d = '0;
    rsp_err = 1'b0; id_rdy = 1'b0;
    tick(); tick(); tick();
    chk_en = 1'b1;
    #1 chk_reset("rst0");

    // basic fetch, one-cycle response
    tick();
    rst = 1'b1; pc_in = 32'h0; req_rdy = 1'b1; id_rdy = 1'b1;
    #1 chk("s1_reqv", req_v, 1'b1);
    chk("s1_hold0", hold, 1'b0);
    tick();
    req_rdy = 1'b0; pc_in = 32'h4;
    rsp_v = 1'b1; rsp_d = 32'h0050_0093;
    #1 chk("s1_hold1", hold, 1'b1);
    tick();
    rsp_v = 1'b0;
    #1 chk("s1_valid", id_v, 1'b1);
    chk("s1_inst", id_inst, 32'h0050_0093);
    chk("s1_pc", id_pc, 32'h0);

    // request not accepted
    tick();
    pc_in = 32'h100;
    for (int i = 0; i < 5; i++) begin
      #1 chk("s2_hold", hold, 1'b1);
      chk("s2_addr", req_a, 32'h100);
      chk("s2_valid", id_v, 1'b0);
      tick();
    end

    // jump while waiting: response dropped
    pc_in = 32'h8; req_rdy = 1'b1;
    #1 chk("s3_reqv", req_v, 1'b1);
    tick();
    req_rdy = 1'b0; pc_in = 32'hC; jump = 1'b1;
    tick();
    jump = 1'b0; pc_in = 32'h200;
    tick();
    tick();
    rsp_v = 1'b1; rsp_d = 32'h1234_5678;
    tick();
    rsp_v = 1'b0; req_rdy = 1'b1;
    #1 chk("s3_novalid", id_v, 1'b0);
    chk("s3_reqv2", req_v, 1'b1);
    chk("s3_addr", req_a, 32'h200);
    tick();
    req_rdy = 1'b0; pc_in = 32'h204;
    rsp_v = 1'b1; rsp_d = 32'h00A0_0113;
    tick();
    rsp_v = 1'b0;
    #1 chk("s3_inst", id_inst, 32'h00A0_0113);
    chk("s3_pc", id_pc, 32'h200);

    // decode backpressure
    tick();
    pc_in = 32'h4; req_rdy = 1'b1;
    tick();
    req_rdy = 1'b0; pc_in = 32'h8;
    rsp_v = 1'b1; rsp_d = 32'h0010_0073; id_rdy = 1'b0;
    tick();
    rsp_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("s4_valid", id_v, 1'b1);
      chk("s4_inst", id_inst, 32'h0010_0073);
      chk("s4_pc", id_pc, 32'h4);
      chk("s4_noreq", req_v, 1'b0);
      tick();
    end
    id_rdy = 1'b1;
    tick();

    // misaligned PC, then bus error
    pc_in = 32'h102; req_rdy = 1'b1; id_rdy = 1'b0;
    #1 chk("s5_noreq", req_v, 1'b0);
    chk("s5_hold", hold, 1'b1);
    tick();
    #1 chk("s5_valid", id_v, 1'b1);
    chk("s5_exc", id_exc, 2'd1);
    chk("s5_pc", id_pc, 32'h102);
    chk("s5_inst", id_inst, NOP);
    id_rdy = 1'b1; pc_in = 32'h20;
    tick();
    #1 chk("s5_reqv", req_v, 1'b1);
    tick();
    req_rdy = 1'b0; pc_in = 32'h24;
    rsp_v = 1'b1; rsp_err = 1'b1; rsp_d = 32'hDEAD_BEEF;
    tick();
    rsp_v = 1'b0; rsp_err = 1'b0;
    #1 chk("s5_exc2", id_exc, 2'd2);
    chk("s5_pc2", id_pc, 32'h20);

    // timeout, late response ignored
    tick();
    pc_in = 32'h40; req_rdy = 1'b1; id_rdy = 1'b0;
    tick();
    req_rdy = 1'b0; pc_in = 32'h44;
    repeat (16) tick();
    #1 chk("s6_valid", id_v, 1'b1);
    chk("s6_exc", id_exc, 2'd3);
    chk("s6_inst", id_inst, NOP);
    chk("s6_pc", id_pc, 32'h40);
    tick();
    rsp_v = 1'b1; rsp_d = 32'hBAD0_0BAD;
    #1 chk("s6_late", id_inst, NOP);
    tick();
    rsp_v = 1'b0; id_rdy = 1'b1;
    #1 chk("s6_exc_hold", id_exc, 2'd3);
    tick();
    req_rdy = 1'b1;
    tick();
    req_rdy = 1'b0; pc_in = 32'h48;
    rsp_v = 1'b1; rsp_d = 32'h0000_0517;
    tick();
    rsp_v = 1'b0;
    #1 chk("s6_next", id_inst, 32'h0000_0517);
    chk("s6_next_pc", id_pc, 32'h44);

    // reset in the middle of a wait
    tick();
    pc_in = 32'h80; req_rdy = 1'b1;
    tick();
    req_rdy = 1'b0; pc_in = 32'h84; rst = 1'b0;
    tick();
    #1 chk_reset("rst1");
    rst = 1'b1; pc_in = 32'h80; jump = 1'b1;
    #1 chk("s7_jump", req_v, 1'b0);
    tick();
    jump = 1'b0; req_rdy = 1'b1;
    #1 chk("s7_reqv", req_v, 1'b1);
    chk("s7_addr", req_a, 32'h80);
    tick();
    req_rdy = 1'b0; pc_in = 32'h84;
    rsp_v = 1'b1; rsp_d = 32'h0000_8067;
    tick();
    rsp_v = 1'b0;
    #1 chk("s7_inst", id_inst, 32'h0000_8067);
    chk("s7_pc", id_pc, 32'h80);
    tick();
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
